// File: rtl/synaptic_weight_accumulator.sv
// Accumulates one neuron's synaptic weight stream into saturating excitatory and
// inhibitory sums, then holds them behind a valid/accept handshake.
module synaptic_weight_accumulator #(
    parameter int INTEGER_WIDTH   = 16,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int COUNT_WIDTH     = 12
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic                          ZeroEvents,
    input  logic                          WeightValid,
    output logic                          WeightReady,
    input  logic signed [DATA_WIDTH-1:0]  Weight,
    input  logic                          SynapseType,
    input  logic                          WeightLast,
    output logic signed [DATA_WIDTH-1:0]  ExWeightSum,
    output logic signed [DATA_WIDTH-1:0]  InWeightSum,
    output logic                          SumValid,
    input  logic                          SumAccept,
    output logic        [COUNT_WIDTH-1:0] EventCount,
    output logic                          Saturated,
    output logic                          Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic signed [DATA_WIDTH-1:0] SUM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SUM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                         state_q, state_d;
    logic signed [DATA_WIDTH-1:0]   ex_sum_q, ex_sum_d;
    logic signed [DATA_WIDTH-1:0]   in_sum_q, in_sum_d;
    logic        [COUNT_WIDTH-1:0]  count_q, count_d;
    logic                           sat_q, sat_d;

    // Saturating add of the incoming weight onto whichever sum the beat targets.
    logic signed [DATA_WIDTH-1:0]   addend;
    logic signed [DATA_WIDTH:0]     wide_sum;
    logic signed [DATA_WIDTH-1:0]   clipped_sum;
    logic                           clip;

    always_comb begin
        addend   = SynapseType ? in_sum_q : ex_sum_q;
        wide_sum = {addend[DATA_WIDTH-1], addend} + {Weight[DATA_WIDTH-1], Weight};
        clip     = wide_sum[DATA_WIDTH] != wide_sum[DATA_WIDTH-1];
        if (!clip) begin
            clipped_sum = wide_sum[DATA_WIDTH-1:0];
        end else if (wide_sum[DATA_WIDTH]) begin
            clipped_sum = SUM_MIN;
        end else begin
            clipped_sum = SUM_MAX;
        end
    end

    always_comb begin
        state_d  = state_q;
        ex_sum_d = ex_sum_q;
        in_sum_d = in_sum_q;
        count_d  = count_q;
        sat_d    = sat_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    ex_sum_d = '0;
                    in_sum_d = '0;
                    count_d  = '0;
                    sat_d    = 1'b0;
                    state_d  = ZeroEvents ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (WeightValid) begin
                    if (SynapseType) begin
                        in_sum_d = clipped_sum;
                    end else begin
                        ex_sum_d = clipped_sum;
                    end
                    if (clip) begin
                        sat_d = 1'b1;
                    end
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                    if (WeightLast) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Accept together with Start chains straight into the next neuron.
                if (SumAccept) begin
                    if (Start) begin
                        ex_sum_d = '0;
                        in_sum_d = '0;
                        count_d  = '0;
                        sat_d    = 1'b0;
                        state_d  = ZeroEvents ? HOLD : ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            ex_sum_q <= '0;
            in_sum_q <= '0;
            count_q  <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ex_sum_q <= ex_sum_d;
            in_sum_q <= in_sum_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
        end
    end

    assign WeightReady = (state_q == ACCUM);
    assign SumValid    = (state_q == HOLD);
    assign Busy        = (state_q != IDLE);
    assign ExWeightSum = ex_sum_q;
    assign InWeightSum = in_sum_q;
    assign EventCount  = count_q;
    assign Saturated   = sat_q;

endmodule

// File: tb/tb_synaptic_weight_accumulator.sv
// Directed and randomized checks of synaptic_weight_accumulator against a
// behavioural model of the accumulate/hold handshake.
module tb_synaptic_weight_accumulator;

    localparam int DW = 48;
    localparam int CW = 12;
    localparam longint MAXV = (longint'(1) <<< (DW-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW-1));
    localparam int CMAX = (1 << CW) - 1;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          ZeroEvents = 1'b0;
    logic          WeightValid = 1'b0;
    logic          WeightReady;
    logic [DW-1:0] Weight = '0;
    logic          SynapseType = 1'b0;
    logic          WeightLast = 1'b0;
    logic [DW-1:0] ExWeightSum;
    logic [DW-1:0] InWeightSum;
    logic          SumValid;
    logic          SumAccept = 1'b0;
    logic [CW-1:0] EventCount;
    logic          Saturated;
    logic          Busy;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    synaptic_weight_accumulator dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .ZeroEvents  (ZeroEvents),
        .WeightValid (WeightValid),
        .WeightReady (WeightReady),
        .Weight      (Weight),
        .SynapseType (SynapseType),
        .WeightLast  (WeightLast),
        .ExWeightSum (ExWeightSum),
        .InWeightSum (InWeightSum),
        .SumValid    (SumValid),
        .SumAccept   (SumAccept),
        .EventCount  (EventCount),
        .Saturated   (Saturated),
        .Busy        (Busy)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = idle, 1 = collecting beats, 2 = result offered.
    int     m_phase = 0;
    longint m_ex = 0;
    longint m_in = 0;
    int     m_cnt = 0;
    bit     m_sat = 1'b0;

    function automatic longint sat_add(input longint a, input longint b, inout bit s);
        longint r;
        r = a + b;
        if (r > MAXV) begin
            r = MAXV;
            s = 1'b1;
        end else if (r < MINV) begin
            r = MINV;
            s = 1'b1;
        end
        return r;
    endfunction

    always @(posedge Clock) begin
        longint w;
        w = longint'($signed(Weight));
        if (Reset) begin
            m_phase = 0; m_ex = 0; m_in = 0; m_cnt = 0; m_sat = 1'b0;
        end else if ((m_phase == 0 && Start) || (m_phase == 2 && SumAccept && Start)) begin
            m_ex = 0; m_in = 0; m_cnt = 0; m_sat = 1'b0;
            m_phase = ZeroEvents ? 2 : 1;
        end else if (m_phase == 2 && SumAccept) begin
            m_phase = 0;
        end else if (m_phase == 1 && WeightValid) begin
            if (SynapseType) m_in = sat_add(m_in, w, m_sat);
            else             m_ex = sat_add(m_ex, w, m_sat);
            if (m_cnt < CMAX) m_cnt++;
            if (WeightLast) m_phase = 2;
        end
    end

    always @(negedge Clock) begin
        logic [DW-1:0] ex_e, in_e;
        if (cmp_en) begin
            ex_e = m_ex[DW-1:0];
            in_e = m_in[DW-1:0];
            check("ex_sum",  64'(ExWeightSum), 64'(ex_e));
            check("in_sum",  64'(InWeightSum), 64'(in_e));
            check("count",   64'(EventCount),  64'(m_cnt));
            check("sat",     64'(Saturated),   64'(m_sat));
            check("ready",   64'(WeightReady), 64'(m_phase == 1));
            check("valid",   64'(SumValid),    64'(m_phase == 2));
            check("busy",    64'(Busy),        64'(m_phase != 0));
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_start(input bit zero);
        Start = 1'b1; ZeroEvents = zero;
        tick();
        Start = 1'b0; ZeroEvents = 1'b0;
    endtask

    task automatic do_beat(input logic [DW-1:0] w, input bit t, input bit last);
        WeightValid = 1'b1; Weight = w; SynapseType = t; WeightLast = last;
        tick();
        WeightValid = 1'b0; WeightLast = 1'b0;
    endtask

    task automatic do_accept();
        SumAccept = 1'b1;
        tick();
        SumAccept = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] w1, w2, w3, w4;
        longint        expect_sum;
        int            r;

        tick();
        cmp_en = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst_ex",    64'(ExWeightSum), 64'h0);
        check("rst_valid", 64'(SumValid),    64'h0);
        check("rst_busy",  64'(Busy),        64'h0);
        check("rst_ready", 64'(WeightReady), 64'h0);

        // Mixed excitatory/inhibitory neuron.
        do_start(1'b0);
        do_beat(48'h0001_0000_0000, 1'b0, 1'b0);
        do_beat(48'hFFFF_8000_0000, 1'b1, 1'b0);
        do_beat(48'h0002_4000_0000, 1'b0, 1'b1);
        check("t1_valid", 64'(SumValid),    64'h1);
        check("t1_ex",    64'(ExWeightSum), 64'h0000_0003_4000_0000);
        check("t1_in",    64'(InWeightSum), 64'h0000_FFFF_8000_0000);
        check("t1_count", 64'(EventCount),  64'd3);
        check("t1_sat",   64'(Saturated),   64'h0);
        // Beat offered while holding must be refused.
        WeightValid = 1'b1; Weight = 48'h0005_0000_0000; SynapseType = 1'b0;
        tick();
        WeightValid = 1'b0;
        check("hold_ready", 64'(WeightReady), 64'h0);
        check("hold_ex",    64'(ExWeightSum), 64'h0000_0003_4000_0000);
        do_accept();
        check("t1_acc_valid", 64'(SumValid), 64'h0);
        check("t1_retain",    64'(ExWeightSum), 64'h0000_0003_4000_0000);

        // Neuron with no events.
        do_start(1'b1);
        check("t2_valid", 64'(SumValid),    64'h1);
        check("t2_ex",    64'(ExWeightSum), 64'h0);
        check("t2_count", 64'(EventCount),  64'd0);
        do_accept();
        check("t2_acc", 64'(SumValid), 64'h0);

        // Positive and negative saturation.
        do_start(1'b0);
        do_beat(48'h7FFF_0000_0000, 1'b0, 1'b0);
        do_beat(48'h7FFF_0000_0000, 1'b0, 1'b0);
        do_beat(48'h8000_0000_0000, 1'b1, 1'b0);
        do_beat(48'h8000_0000_0000, 1'b1, 1'b1);
        check("t3_ex",  64'(ExWeightSum), 64'h0000_7FFF_FFFF_FFFF);
        check("t3_in",  64'(InWeightSum), 64'h0000_8000_0000_0000);
        check("t3_sat", 64'(Saturated),   64'h1);
        do_accept();

        // Stalled stream: beat, two idle cycles, then three more beats.
        w1 = 48'h0000_1234_5678; w2 = 48'hFFFF_FFFF_0000;
        w3 = 48'h0003_0000_0001; w4 = 48'h0000_0000_0010;
        expect_sum = longint'($signed(w1)) + longint'($signed(w2))
                   + longint'($signed(w3)) + longint'($signed(w4));
        do_start(1'b0);
        do_beat(w1, 1'b0, 1'b0);
        tick();
        tick();
        check("t4_stall_ready", 64'(WeightReady), 64'h1);
        check("t4_stall_valid", 64'(SumValid),    64'h0);
        do_beat(w2, 1'b0, 1'b0);
        do_beat(w3, 1'b0, 1'b0);
        do_beat(w4, 1'b0, 1'b1);
        check("t4_ex",    64'(ExWeightSum), 64'(expect_sum[DW-1:0]));
        check("t4_valid", 64'(SumValid),    64'h1);

        // Back-to-back: accept and start together.
        SumAccept = 1'b1; Start = 1'b1; ZeroEvents = 1'b0;
        tick();
        SumAccept = 1'b0; Start = 1'b0;
        check("t5_ready", 64'(WeightReady), 64'h1);
        check("t5_valid", 64'(SumValid),    64'h0);
        check("t5_ex",    64'(ExWeightSum), 64'h0);
        do_beat(48'h0000_0000_0100, 1'b1, 1'b1);
        check("t5_in", 64'(InWeightSum), 64'h0000_0000_0000_0100);
        do_accept();

        // Reset mid-accumulation.
        do_start(1'b0);
        do_beat(48'h0001_0000_0000, 1'b0, 1'b0);
        do_beat(48'h0001_0000_0000, 1'b1, 1'b0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("t6_ex",    64'(ExWeightSum), 64'h0);
        check("t6_in",    64'(InWeightSum), 64'h0);
        check("t6_count", 64'(EventCount),  64'h0);
        check("t6_busy",  64'(Busy),        64'h0);
        do_start(1'b0);
        do_beat(48'h0000_0000_0007, 1'b0, 1'b1);
        check("t6_restart", 64'(ExWeightSum), 64'h0000_0000_0000_0007);
        do_accept();

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            Reset       = ($urandom_range(0, 79) == 0);
            Start       = ($urandom_range(0, 3) == 0);
            ZeroEvents  = ($urandom_range(0, 5) == 0);
            WeightValid = ($urandom_range(0, 9) < 6);
            SumAccept   = ($urandom_range(0, 2) == 0);
            SynapseType = $urandom_range(0, 1) == 1;
            WeightLast  = ($urandom_range(0, 4) == 0);
            if (r < 20) Weight = DW'({$urandom, $urandom});
            else        Weight = DW'($signed(32'($urandom_range(0, 65535)) - 32'd32768)) <<< 16;
            tick();
        end
        Reset = 1'b0; Start = 1'b0; WeightValid = 1'b0; SumAccept = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
